sequence_detector: RTL and testbench



---
 rtl/sequence_detector.sv | 59 +++++
 tb/tb_sequence_detector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sequence_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sequence_detector
// Purpose  : Moore-model serial detector for the pattern "101". Overlapping
//            occurrences are detected. det_o is high for one cycle while
//            the FSM is in its "101 seen" state.
// Ports    : clock   - system clock, rising-edge active
//            reset   - synchronous, active-high reset (priority over seq_in)
//            seq_in  - serial data bit, sampled on the rising edge
//            det_o   - detect flag, a pure decode of the state register
//            state_o - current FSM state, for debug and observability
// Revision : 1.0 - initial release
// ============================================================================
module sequence_detector (
    input  logic       clock,
    input  logic       reset,
    input  logic       seq_in,
    output logic       det_o,
    output logic [1:0] state_o
);

    // All four codes are legal, so there is no unreachable state to recover from.
    typedef enum logic [1:0] {
        S0 = 2'b00,   // idle, no useful prefix
        S1 = 2'b01,   // "1" seen
        S2 = 2'b10,   // "10" seen
        S3 = 2'b11    // "101" seen
    } state_t;

    state_t state;
    state_t next_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S0: next_state = seq_in ? S1 : S0;
            S1: next_state = seq_in ? S1 : S2;
            S2: next_state = seq_in ? S3 : S0;
            // From S3 the trailing bits are reused: "1" alone or "10".
            S3: next_state = seq_in ? S1 : S2;
            default: next_state = S0;
        endcase
    end

    // Moore outputs: no path from seq_in to det_o.
    assign det_o   = (state == S3);
    assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_sequence_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sequence_detector
// Purpose  : Self-checking bench for sequence_detector. A history-based
//            model of the "101" detector is compared to the DUT every cycle,
//            and directed vectors carry hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_detector;

    logic       clock;
    logic       reset;
    logic       seq_in;
    logic       det_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    sequence_detector dut (
        .clock   (clock),
        .reset   (reset),
        .seq_in  (seq_in),
        .det_o   (det_o),
        .state_o (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Model: the last three accepted bits and how many bits were accepted
    // since reset. The expected state is the longest suffix of the history
    // that is a prefix of "101".
    // ------------------------------------------------------------------
    logic [2:0] hist  = 3'b000;
    int         nbits = 0;
    bit         valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            hist  <= 3'b000;
            nbits <= 0;
            valid <= 1'b1;
        end else if (valid) begin
            hist  <= {hist[1:0], seq_in};
            nbits <= (nbits < 3) ? nbits + 1 : 3;
        end
    end

    function automatic logic [1:0] model_state(input logic [2:0] h, input int n);
        if (n >= 3 && h == 3'b101)      return 2'd3;
        else if (n >= 2 && h[1:0] == 2'b10) return 2'd2;
        else if (n >= 1 && h[0])        return 2'd1;
        else                            return 2'd0;
    endfunction

    // Outputs only change on the rising edge, so sample on the falling edge.
    always @(negedge clock) begin
        if (valid) begin
            checks = checks + 1;
            if (state_o !== model_state(hist, nbits) ||
                det_o !== (model_state(hist, nbits) == 2'd3)) begin
                errors = errors + 1;
                $display("FAIL model_cmp t=%0t: state_o=%b det_o=%b, required state_o=%b det_o=%b",
                         $time, state_o, det_o, model_state(hist, nbits),
                         (model_state(hist, nbits) == 2'd3));
            end
        end
    end

    // Drive one bit (and reset) on the falling edge, check just after the rising edge.
    task automatic step(input logic rst, input logic b,
                        input logic [1:0] exp_st, input logic exp_det,
                        input string name);
        @(negedge clock);
        reset  = rst;
        seq_in = b;
        @(posedge clock);
        #1;
        checks = checks + 1;
        if (state_o !== exp_st || det_o !== exp_det) begin
            errors = errors + 1;
            $display("FAIL %s: state_o=%b det_o=%b, required state_o=%b det_o=%b",
                     name, state_o, det_o, exp_st, exp_det);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        seq_in = 1'b0;

        // Reset with seq_in=0
        step(1'b1, 1'b0, 2'b00, 1'b0, "reset");

        // Overlapping stream 0,1,0,1,0,1,1
        step(1'b0, 1'b0, 2'b00, 1'b0, "ovl_1");
        step(1'b0, 1'b1, 2'b01, 1'b0, "ovl_2");
        step(1'b0, 1'b0, 2'b10, 1'b0, "ovl_3");
        step(1'b0, 1'b1, 2'b11, 1'b1, "ovl_4");
        step(1'b0, 1'b0, 2'b10, 1'b0, "ovl_5");
        step(1'b0, 1'b1, 2'b11, 1'b1, "ovl_6");
        step(1'b0, 1'b1, 2'b01, 1'b0, "ovl_7");

        // Mid-stream reset, then 1,0,1,1
        step(1'b1, 1'b0, 2'b00, 1'b0, "mid_reset");
        step(1'b0, 1'b1, 2'b01, 1'b0, "basic_1");
        step(1'b0, 1'b0, 2'b10, 1'b0, "basic_2");
        step(1'b0, 1'b1, 2'b11, 1'b1, "basic_3");
        step(1'b0, 1'b1, 2'b01, 1'b0, "basic_4");

        // Non-matching stream 1,1,0,0,1,0,0
        step(1'b0, 1'b1, 2'b01, 1'b0, "nomatch_1");
        step(1'b0, 1'b1, 2'b01, 1'b0, "nomatch_2");
        step(1'b0, 1'b0, 2'b10, 1'b0, "nomatch_3");
        step(1'b0, 1'b0, 2'b00, 1'b0, "nomatch_4");
        step(1'b0, 1'b1, 2'b01, 1'b0, "nomatch_5");
        step(1'b0, 1'b0, 2'b10, 1'b0, "nomatch_6");
        step(1'b0, 1'b0, 2'b00, 1'b0, "nomatch_7");

        // Reset priority: reach S2, then seq_in=1 together with reset
        step(1'b0, 1'b1, 2'b01, 1'b0, "prio_pre1");
        step(1'b0, 1'b0, 2'b10, 1'b0, "prio_pre2");
        step(1'b1, 1'b1, 2'b00, 1'b0, "prio_reset");

        // Repeated pattern 1,0,1,0,1,0,1 then a trailing 0
        step(1'b0, 1'b1, 2'b01, 1'b0, "rep_1");
        step(1'b0, 1'b0, 2'b10, 1'b0, "rep_2");
        step(1'b0, 1'b1, 2'b11, 1'b1, "rep_3");
        step(1'b0, 1'b0, 2'b10, 1'b0, "rep_4");
        step(1'b0, 1'b1, 2'b11, 1'b1, "rep_5");
        step(1'b0, 1'b0, 2'b10, 1'b0, "rep_6");
        step(1'b0, 1'b1, 2'b11, 1'b1, "rep_7");
        step(1'b0, 1'b0, 2'b10, 1'b0, "rep_tail");

        // Let the last cycle's falling-edge model compare run.
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
